// File: rtl/d2_uop_sequencer.sv
// D2 micro-op sequencer: selects the control-store address source, counts the
// micro-ops of a macro-instruction, squashes on interrupt/REPNE termination and
// flags runaway sequences that exceed MAX_UOPS.
module d2_uop_sequencer #(
    parameter int unsigned UADDR_W  = 8,
    parameter int unsigned MAX_UOPS = 8,
    parameter int unsigned CNT_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               d2_v,
    input  logic               ld_d2,
    input  logic [UADDR_W-1:0] decode_addr,
    input  logic               decode_op_size,
    input  logic [UADDR_W-1:0] cs_next_uaddr,
    input  logic               cs_uop_stall,
    input  logic               int_exist,
    input  logic               repne_terminate,
    output logic [UADDR_W-1:0] cs_addr,
    output logic               cs_op_size,
    output logic               sel_uop,
    output logic [CNT_W-1:0]   uop_idx,
    output logic               uop_stall_out,
    output logic               uop_last,
    output logic               seq_fault
);

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_UOPS - 1);

    state_t             state_q, state_d;
    logic [UADDR_W-1:0] saved_uaddr_q, saved_uaddr_d;
    logic [CNT_W-1:0]   uop_idx_q, uop_idx_d;
    logic               seq_fault_q, seq_fault_d;

    logic squash;
    logic cont;

    // Next-state logic and combinational outputs; state only advances on ld_d2.
    always_comb begin
        state_d       = state_q;
        saved_uaddr_d = saved_uaddr_q;
        uop_idx_d     = uop_idx_q;
        seq_fault_d   = 1'b0;

        squash = int_exist | repne_terminate;
        cont   = d2_v & cs_uop_stall & ~squash;

        if (ld_d2) begin
            case (state_q)
                IDLE: begin
                    if (cont) begin
                        state_d       = SEQ;
                        saved_uaddr_d = cs_next_uaddr;
                        uop_idx_d     = CNT_W'(1);
                    end else begin
                        uop_idx_d     = '0;
                    end
                end
                SEQ: begin
                    if (cont && (uop_idx_q != LAST_IDX)) begin
                        saved_uaddr_d = cs_next_uaddr;
                        uop_idx_d     = uop_idx_q + CNT_W'(1);
                    end else begin
                        // Either the sequence ended normally/was squashed, or it ran
                        // past the micro-op budget and is forcibly terminated.
                        state_d     = IDLE;
                        uop_idx_d   = '0;
                        seq_fault_d = cont;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    uop_idx_d = '0;
                end
            endcase
        end

        sel_uop       = (state_q == SEQ);
        cs_addr       = sel_uop ? saved_uaddr_q : decode_addr;
        cs_op_size    = sel_uop ? 1'b0 : decode_op_size;
        uop_stall_out = cont;
        uop_last      = d2_v & ~cont;
        uop_idx       = uop_idx_q;
        seq_fault     = seq_fault_q;
    end

    // State, saved micro-address, index and fault pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            saved_uaddr_q <= '0;
            uop_idx_q     <= '0;
            seq_fault_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            saved_uaddr_q <= saved_uaddr_d;
            uop_idx_q     <= uop_idx_d;
            seq_fault_q   <= seq_fault_d;
        end
    end

endmodule

// File: tb/tb_d2_uop_sequencer.sv
// Self-checking bench for d2_uop_sequencer: directed scenarios then random
// traffic, checked against a count-based reference model for two budgets.
module tb_d2_uop_sequencer;

    logic       clk = 1'b0;
    logic       reset, d2_v, ld_d2, decode_op_size, cs_uop_stall;
    logic       int_exist, repne_terminate;
    logic [7:0] decode_addr, cs_next_uaddr;

    logic [7:0] a_cs_addr, b_cs_addr;
    logic       a_op, a_sel, a_stall, a_last, a_fault;
    logic       b_op, b_sel, b_stall, b_last, b_fault;
    logic [2:0] a_idx;
    logic [1:0] b_idx;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Reference model: number of uops already issued in the current macro-op
    // (0 means the next uop comes from decode), last saved address, fault flag.
    int unsigned ma_n, mb_n;
    logic [7:0]  ma_s, mb_s;
    logic        ma_f, mb_f;

    always #5 clk = ~clk;

    d2_uop_sequencer #(.UADDR_W(8), .MAX_UOPS(8), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset), .d2_v(d2_v), .ld_d2(ld_d2),
        .decode_addr(decode_addr), .decode_op_size(decode_op_size),
        .cs_next_uaddr(cs_next_uaddr), .cs_uop_stall(cs_uop_stall),
        .int_exist(int_exist), .repne_terminate(repne_terminate),
        .cs_addr(a_cs_addr), .cs_op_size(a_op), .sel_uop(a_sel), .uop_idx(a_idx),
        .uop_stall_out(a_stall), .uop_last(a_last), .seq_fault(a_fault)
    );

    d2_uop_sequencer #(.UADDR_W(8), .MAX_UOPS(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .d2_v(d2_v), .ld_d2(ld_d2),
        .decode_addr(decode_addr), .decode_op_size(decode_op_size),
        .cs_next_uaddr(cs_next_uaddr), .cs_uop_stall(cs_uop_stall),
        .int_exist(int_exist), .repne_terminate(repne_terminate),
        .cs_addr(b_cs_addr), .cs_op_size(b_op), .sel_uop(b_sel), .uop_idx(b_idx),
        .uop_stall_out(b_stall), .uop_last(b_last), .seq_fault(b_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_one(input string p, input int unsigned n, input logic [7:0] s,
                             input logic f, input logic [7:0] addr, input logic op,
                             input logic sel, input logic [31:0] idx, input logic stl,
                             input logic lst, input logic flt);
        logic cont;
        cont = d2_v & cs_uop_stall & ~(int_exist | repne_terminate);
        chk({p, "_sel"},   {31'd0, sel}, {31'd0, n > 0});
        chk({p, "_addr"},  {24'd0, addr}, {24'd0, (n > 0) ? s : decode_addr});
        chk({p, "_op"},    {31'd0, op}, {31'd0, (n > 0) ? 1'b0 : decode_op_size});
        chk({p, "_idx"},   idx, n);
        chk({p, "_stall"}, {31'd0, stl}, {31'd0, cont});
        chk({p, "_last"},  {31'd0, lst}, {31'd0, d2_v & ~cont});
        chk({p, "_fault"}, {31'd0, flt}, {31'd0, f});
    endtask

    task automatic model_edge(input int unsigned max, inout int unsigned n,
                              inout logic [7:0] s, inout logic f);
        logic cont;
        cont = d2_v & cs_uop_stall & ~(int_exist | repne_terminate);
        if (reset) begin
            n = 0; s = '0; f = 1'b0;
        end else begin
            f = ld_d2 & cont & (n == max - 1);
            if (ld_d2) begin
                if (cont && n < max - 1) begin
                    s = cs_next_uaddr;
                    n = n + 1;
                end else begin
                    n = 0;
                end
            end
        end
    endtask

    // Apply inputs, let them settle, and compare every output of both instances.
    task automatic drive(input logic v, input logic ld, input logic [7:0] da, input logic op,
                         input logic [7:0] nx, input logic st, input logic intr,
                         input logic rep, input logic rst);
        d2_v = v; ld_d2 = ld; decode_addr = da; decode_op_size = op;
        cs_next_uaddr = nx; cs_uop_stall = st; int_exist = intr;
        repne_terminate = rep; reset = rst;
        #2;
        check_one("A", ma_n, ma_s, ma_f, a_cs_addr, a_op, a_sel, {29'd0, a_idx},
                  a_stall, a_last, a_fault);
        check_one("B", mb_n, mb_s, mb_f, b_cs_addr, b_op, b_sel, {30'd0, b_idx},
                  b_stall, b_last, b_fault);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(8, ma_n, ma_s, ma_f);
        model_edge(4, mb_n, mb_s, mb_f);
        #1;
    endtask

    initial begin
        ma_n = 0; mb_n = 0; ma_s = '0; mb_s = '0; ma_f = 1'b0; mb_f = 1'b0;
        d2_v = 0; ld_d2 = 0; decode_addr = '0; decode_op_size = 0; cs_next_uaddr = '0;
        cs_uop_stall = 0; int_exist = 0; repne_terminate = 0; reset = 1;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        chk("rst_sel", {31'd0, a_sel}, 32'd0);
        chk("rst_idx", {29'd0, a_idx}, 32'd0);
        chk("rst_fault", {31'd0, a_fault}, 32'd0);

        // Single-uop instruction
        drive(1, 1, 8'h2A, 1, 8'h77, 0, 0, 0, 0);
        chk("t1_addr", {24'd0, a_cs_addr}, 32'h2A);
        chk("t1_last", {31'd0, a_last}, 32'd1);
        chk("t1_stall", {31'd0, a_stall}, 32'd0);
        tick();
        drive(0, 1, 8'h2A, 0, 8'h00, 0, 0, 0, 0);
        chk("t1_idle", {31'd0, a_sel}, 32'd0);
        tick();

        // Three-uop sequence with a 3-cycle AG stall at uop 1
        drive(1, 1, 8'h10, 1, 8'h41, 1, 0, 0, 0);
        chk("t2_addr0", {24'd0, a_cs_addr}, 32'h10);
        chk("t2_stall0", {31'd0, a_stall}, 32'd1);
        tick();
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1, 0, 8'h99, 1, 8'h42, 1, 0, 0, 0);
            chk("t3_addr", {24'd0, a_cs_addr}, 32'h41);
            chk("t3_idx", {29'd0, a_idx}, 32'd1);
            tick();
        end
        drive(1, 1, 8'h99, 1, 8'h42, 1, 0, 0, 0);
        chk("t2_addr1", {24'd0, a_cs_addr}, 32'h41);
        chk("t2_op1", {31'd0, a_op}, 32'd0);
        tick();
        drive(1, 1, 8'h99, 1, 8'h43, 0, 0, 0, 0);
        chk("t2_addr2", {24'd0, a_cs_addr}, 32'h42);
        chk("t2_idx2", {29'd0, a_idx}, 32'd2);
        chk("t2_stall2", {31'd0, a_stall}, 32'd0);
        tick();

        // Squash by interrupt at uop 1
        drive(1, 1, 8'h20, 0, 8'h55, 1, 0, 0, 0);
        tick();
        drive(1, 1, 8'h20, 0, 8'h56, 1, 1, 0, 0);
        chk("t4_stall", {31'd0, a_stall}, 32'd0);
        tick();
        drive(1, 1, 8'h33, 0, 8'h00, 0, 0, 0, 0);
        chk("t4_sel", {31'd0, a_sel}, 32'd0);
        chk("t4_addr", {24'd0, a_cs_addr}, 32'h33);
        tick();

        // Runaway on the MAX_UOPS=4 instance
        for (int unsigned i = 0; i < 5; i++) begin
            drive(1, 1, 8'h60, 0, 8'(8'h61 + i), 1, 0, 0, 0);
            chk("t5_idx", {30'd0, b_idx}, i % 4);
            chk("t5_fault", {31'd0, b_fault}, {31'd0, i == 4});
            tick();
        end
        drive(1, 1, 8'h60, 0, 8'h70, 0, 0, 0, 0);
        chk("t5_fault_end", {31'd0, b_fault}, 32'd0);
        tick();
        drive(0, 1, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        tick();

        // Reset mid-sequence at uop 2
        drive(1, 1, 8'h80, 0, 8'h81, 1, 0, 0, 0);
        tick();
        drive(1, 1, 8'h80, 0, 8'h82, 1, 0, 0, 0);
        tick();
        drive(1, 1, 8'h80, 0, 8'h83, 1, 0, 0, 1);
        chk("t6_idx_before", {29'd0, a_idx}, 32'd2);
        tick();
        drive(1, 0, 8'h80, 0, 8'h84, 0, 0, 0, 0);
        chk("t6_sel", {31'd0, a_sel}, 32'd0);
        chk("t6_idx", {29'd0, a_idx}, 32'd0);
        chk("t6_fault", {31'd0, a_fault}, 32'd0);
        tick();

        // Random traffic, biased toward long sequences
        for (int unsigned i = 0; i < 3000; i++) begin
            drive(($urandom_range(9) != 0), ($urandom_range(3) != 0), 8'($urandom),
                  1'($urandom), 8'($urandom), ($urandom_range(9) > 1),
                  ($urandom_range(29) == 0), ($urandom_range(29) == 0),
                  ($urandom_range(199) == 0));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/d2_uop_sequencer.md
Name: d2_uop_sequencer

Overview:
- Parametrised micro-op sequencer for decode stage 2.
- Generalises the single-bit "continue micro-op" latch into a counted state machine:
  - configurable control-store address width and maximum micro-ops per macro-instruction;
  - squash on interrupt or REPNE terminate;
  - runaway-sequence fault detection.
- Drives the control-store address mux select and the D2 micro-op stall toward fetch/D1.

Parameters:
- UADDR_W, 8, control-store address width (decode address and next-micro-address width).
- MAX_UOPS, 8, maximum micro-ops allowed per macro-instruction, including the first; range 2..256.
- CNT_W, 3, width of the micro-op index, equal to ceil(log2(MAX_UOPS)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- d2_v  in  1  D2 holds a valid macro-instruction
- ld_d2  in  1  downstream (AG) accepts D2 this cycle (AG not stalled)
- decode_addr  in  UADDR_W  first-uop control-store address from D1
- decode_op_size  in  1  opcode_size from D1, used for the first uop only
- cs_next_uaddr  in  UADDR_W  next-micro-address field of the current control word
- cs_uop_stall  in  1  current control word requests another uop
- int_exist  in  1  interrupt pending; squashes sequencing
- repne_terminate  in  1  WB REPNE termination; squashes sequencing
- cs_addr  out  UADDR_W  control-store address for this cycle
- cs_op_size  out  1  opcode_size to the control store
- sel_uop  out  1  1 = cs_addr comes from the saved next-micro-address
- uop_idx  out  CNT_W  index of the uop currently in D2 (0 = first)
- uop_stall_out  out  1  hold fetch/D1; D2 will issue another uop
- uop_last  out  1  current uop is the final one of the macro-instruction
- seq_fault  out  1  one-cycle pulse: MAX_UOPS exceeded, sequence forcibly ended

Behaviour:
- Reset (clk edge with reset=1) forces:
  - state=IDLE, saved_uaddr=0, uop_idx=0;
  - sel_uop=0, seq_fault=0.
- States: IDLE (first uop taken from decode_addr) and SEQ (uop taken from saved_uaddr).
- squash = int_exist | repne_terminate.
- cont = d2_v & cs_uop_stall & ~squash.
- Combinational outputs:
  - cs_addr = sel_uop ? saved_uaddr : decode_addr.
  - cs_op_size = sel_uop ? 0 : decode_op_size.
  - sel_uop = (state==SEQ).
  - uop_stall_out = cont.
  - uop_last = d2_v & ~cont.
- Registered update occurs only when ld_d2=1. When ld_d2=0, state, saved_uaddr and uop_idx all hold; squash is still reflected combinationally.
- Transitions when ld_d2=1:
  - IDLE, cont=1: go to SEQ; saved_uaddr<=cs_next_uaddr; uop_idx<=1.
  - IDLE, cont=0: stay in IDLE; uop_idx=0.
  - SEQ, cont=1, uop_idx<MAX_UOPS-1: stay in SEQ; saved_uaddr<=cs_next_uaddr; uop_idx+=1.
  - SEQ, cont=1, uop_idx==MAX_UOPS-1: go to IDLE; uop_idx<=0; seq_fault pulses high for the following cycle.
  - SEQ, cont=0: go to IDLE; uop_idx<=0.
- Squash in SEQ: cont=0, so the sequence returns to IDLE on the next ld_d2. This applies even if cs_uop_stall=1.
- d2_v=0 in SEQ with ld_d2=1 (bubble): return to IDLE. An invalid slot never continues a sequence.
- Latency:
  - the next-micro-address is visible on cs_addr exactly one ld_d2 cycle after being presented;
  - the first uop has zero added latency.
- Wrap-around: uop_idx never exceeds MAX_UOPS-1.
- Saved address: saved_uaddr is stored at full UADDR_W with no truncation.
- Reset mid-sequence: immediate return to IDLE, with no fault pulse.

Test Plan:
1. Single-uop instruction: d2_v=1, decode_addr=0x2A, cs_uop_stall=0, ld_d2=1.
   - cs_addr=0x2A, sel_uop=0, uop_last=1, uop_stall_out=0.
   - Remains IDLE.
2. Three-uop sequence: decode_addr=0x10; next addresses 0x41 then 0x42; cs_uop_stall=1,1,0.
   - cs_addr per cycle: 0x10, 0x41, 0x42.
   - uop_idx per cycle: 0, 1, 2.
   - uop_stall_out per cycle: 1, 1, 0.
   - cs_op_size=0 on the 2nd and 3rd uops.
3. AG stall mid-sequence: at uop_idx=1, drop ld_d2 for 3 cycles.
   - cs_addr=0x41 and uop_idx=1 held for all 3 cycles.
   - Resumes to 0x42 when ld_d2 returns.
4. Squash: at uop_idx=1, assert int_exist with cs_uop_stall=1, ld_d2=1.
   - uop_stall_out=0.
   - Next cycle: state IDLE, sel_uop=0, cs_addr=decode_addr.
5. Runaway: MAX_UOPS=4, cs_uop_stall held at 1.
   - uop_idx goes 0, 1, 2, 3, then back to 0.
   - seq_fault=1 for exactly one cycle after idx 3.
6. Reset in SEQ: assert reset at uop_idx=2.
   - Next cycle: sel_uop=0, uop_idx=0, seq_fault=0.
